blink_rate_select: RTL and testbench

//  Upstream control stage for the LED blinker. It debounces the on-board push button and

---
 rtl/blink_rate_select.sv | 194 +++++++++++++++++++
 tb/tb_blink_rate_select.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/blink_rate_select.sv
// Button-driven rate selector for the LED blinker: 1 ms prescaler, button synchroniser,
// debounce FSM and a four-entry half-period table stepped once per accepted press.
module blink_rate_select #(
  parameter int unsigned CLOCK_FREQUENCY   = 27000000,
  parameter int unsigned DEBOUNCE_MS       = 20,
  parameter int unsigned RATE0_MS          = 500,
  parameter int unsigned RATE1_MS          = 250,
  parameter int unsigned RATE2_MS          = 100,
  parameter int unsigned RATE3_MS          = 50,
  parameter int unsigned BUTTON_ACTIVE_LOW = 1
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        Button_raw,
  output logic        Ms_tick,
  output logic [1:0]  Rate_index,
  output logic [15:0] Half_period_ms,
  output logic        Rate_changed
);

  localparam int unsigned PRESCALE = CLOCK_FREQUENCY / 1000;
  localparam int unsigned PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned DEB_W    = $clog2(DEBOUNCE_MS + 1);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_MS - 1);
  localparam logic [DEB_W-1:0] DEB_MAX  = {DEB_W{1'b1}};
  localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);
  localparam logic             RELEASED_LEVEL = (BUTTON_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_WAIT_PRESS   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_WAIT_RELEASE = 2'd3
  } state_t;

  function automatic logic [15:0] rate_lookup(input logic [1:0] idx);
    logic [15:0] val;
    case (idx)
      2'd0:    val = 16'(RATE0_MS);
      2'd1:    val = 16'(RATE1_MS);
      2'd2:    val = 16'(RATE2_MS);
      2'd3:    val = 16'(RATE3_MS);
      default: val = 16'(RATE0_MS);
    endcase
    return val;
  endfunction

  // Counter never wraps: it holds at all-ones if ever pushed that far.
  function automatic logic [DEB_W-1:0] sat_inc(input logic [DEB_W-1:0] val);
    logic [DEB_W-1:0] res;
    if (val == DEB_MAX) begin
      res = val;
    end else begin
      res = val + DEB_ONE;
    end
    return res;
  endfunction

  logic [PRE_W-1:0] pre_cnt_r;
  logic             ms_tick_r;
  logic [1:0]       sync_r;
  logic             pressed_s;
  state_t           state_r;
  state_t           state_s;
  logic [DEB_W-1:0] deb_cnt_r;
  logic [DEB_W-1:0] deb_cnt_s;
  logic             accept_s;
  logic [1:0]       next_index_s;
  logic [1:0]       rate_index_r;
  logic [15:0]      half_period_r;
  logic             rate_changed_r;

  // Free-running 1 ms prescaler with a registered tick.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      pre_cnt_r <= '0;
      ms_tick_r <= 1'b0;
    end else if (pre_cnt_r == PRE_LAST) begin
      pre_cnt_r <= '0;
      ms_tick_r <= 1'b1;
    end else begin
      pre_cnt_r <= pre_cnt_r + PRE_ONE;
      ms_tick_r <= 1'b0;
    end
  end

  // Two-flop synchroniser; resets to the released level so no press is seen at reset.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      sync_r <= {2{RELEASED_LEVEL}};
    end else begin
      sync_r <= {sync_r[0], Button_raw};
    end
  end

  assign pressed_s = sync_r[1] ^ RELEASED_LEVEL;

  // Debounce state and tick counter registers.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r   <= ST_IDLE;
      deb_cnt_r <= '0;
    end else begin
      state_r   <= state_s;
      deb_cnt_r <= deb_cnt_s;
    end
  end

  // Debounce next-state logic; a level change must survive DEBOUNCE_MS ticks to be accepted.
  always_comb begin
    state_s   = state_r;
    deb_cnt_s = deb_cnt_r;
    accept_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pressed_s) begin
          state_s   = ST_WAIT_PRESS;
          deb_cnt_s = '0;
        end else begin
          state_s   = ST_IDLE;
        end
      end
      ST_WAIT_PRESS: begin
        // Release is tested first so it wins over a coincident final tick.
        if (!pressed_s) begin
          state_s = ST_IDLE;
        end else if (ms_tick_r) begin
          if (deb_cnt_r == DEB_LAST) begin
            state_s  = ST_PRESSED;
            accept_s = 1'b1;
          end else begin
            deb_cnt_s = sat_inc(deb_cnt_r);
          end
        end else begin
          state_s = ST_WAIT_PRESS;
        end
      end
      ST_PRESSED: begin
        if (!pressed_s) begin
          state_s   = ST_WAIT_RELEASE;
          deb_cnt_s = '0;
        end else begin
          state_s   = ST_PRESSED;
        end
      end
      ST_WAIT_RELEASE: begin
        if (pressed_s) begin
          state_s = ST_PRESSED;
        end else if (ms_tick_r) begin
          if (deb_cnt_r == DEB_LAST) begin
            state_s = ST_IDLE;
          end else begin
            deb_cnt_s = sat_inc(deb_cnt_r);
          end
        end else begin
          state_s = ST_WAIT_RELEASE;
        end
      end
      default: begin
        state_s   = ST_IDLE;
        deb_cnt_s = '0;
      end
    endcase
  end

  assign next_index_s = rate_index_r + 2'd1;

  // Rate selection registers; they move only on an accepted press.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      rate_index_r   <= 2'd0;
      half_period_r  <= 16'(RATE0_MS);
      rate_changed_r <= 1'b0;
    end else begin
      rate_changed_r <= accept_s;
      if (accept_s) begin
        rate_index_r  <= next_index_s;
        half_period_r <= rate_lookup(next_index_s);
      end else begin
        rate_index_r  <= rate_index_r;
        half_period_r <= half_period_r;
      end
    end
  end

  assign Ms_tick        = ms_tick_r;
  assign Rate_index     = rate_index_r;
  assign Half_period_ms = half_period_r;
  assign Rate_changed   = rate_changed_r;

endmodule

// File: tb/tb_blink_rate_select.sv
// Self-checking bench for blink_rate_select: directed scenarios plus random button activity,
// compared every cycle against a level/tick-counting behavioural model.
module tb_blink_rate_select;

  localparam int unsigned CF  = 10000;
  localparam int unsigned P   = CF / 1000;
  localparam int unsigned DEB = 3;

  logic        Clock = 1'b0;
  logic        Reset_n = 1'b1;
  logic        Button_raw = 1'b1;
  logic        Ms_tick;
  logic [1:0]  Rate_index;
  logic [15:0] Half_period_ms;
  logic        Rate_changed;

  blink_rate_select #(
    .CLOCK_FREQUENCY(CF), .DEBOUNCE_MS(DEB), .RATE0_MS(500), .RATE1_MS(250),
    .RATE2_MS(100), .RATE3_MS(50), .BUTTON_ACTIVE_LOW(1)
  ) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Button_raw(Button_raw), .Ms_tick(Ms_tick),
    .Rate_index(Rate_index), .Half_period_ms(Half_period_ms), .Rate_changed(Rate_changed)
  );

  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pulse  = 0;
  int rates[4] = '{500, 250, 100, 50};

  // Model: synchronised level, accepted (debounced) level, pending flag and ticks seen.
  bit m_s1 = 1'b1, m_s2 = 1'b1, m_deb = 1'b0, m_pending = 1'b0;
  int m_ticks = 0, m_cyc = 0, m_idx = 0;
  bit exp_tick = 1'b0, exp_changed = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    bit pressed_seen, tick_seen;
    forever begin
      @(posedge Clock or negedge Reset_n);
      if (!Reset_n) begin
        m_s1 = 1'b1; m_s2 = 1'b1; m_deb = 1'b0; m_pending = 1'b0;
        m_ticks = 0; m_cyc = 0; m_idx = 0; exp_tick = 1'b0; exp_changed = 1'b0;
      end else begin
        pressed_seen = ~m_s2;
        tick_seen    = exp_tick;
        exp_changed  = 1'b0;
        if (pressed_seen == m_deb) begin
          m_pending = 1'b0;
        end else if (!m_pending) begin
          m_pending = 1'b1;
          m_ticks   = 0;
        end else if (tick_seen) begin
          m_ticks++;
          if (m_ticks == DEB) begin
            m_deb     = pressed_seen;
            m_pending = 1'b0;
            if (m_deb) begin
              m_idx       = (m_idx + 1) % 4;
              exp_changed = 1'b1;
            end
          end
        end
        m_s2 = m_s1;
        m_s1 = Button_raw;
        m_cyc++;
        exp_tick = ((m_cyc % P) == 0);
      end
    end
  end

  initial begin
    forever begin
      @(negedge Clock);
      if (Rate_changed) n_pulse++;
      check("ms_tick", int'(Ms_tick), int'(exp_tick));
      check("rate_changed", int'(Rate_changed), int'(exp_changed));
      check("rate_index", int'(Rate_index), m_idx);
      check("half_period", int'(Half_period_ms), rates[m_idx]);
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge Clock);
  endtask

  // Button already driven; watch 60 edges for the accept pulse and check its latency.
  task automatic measure_accept(input string name);
    int lat = -1;
    for (int i = 0; i < 60; i++) begin
      @(posedge Clock);
      #1;
      if (Rate_changed && lat < 0) lat = i;
    end
    @(negedge Clock);
    check(name, int'(lat >= 20 && lat <= 32), 1);
    if (lat < 20 || lat > 32) $display("  latency observed %0d clk", lat);
  endtask

  task automatic press_release(input string name);
    Button_raw = 1'b0;
    measure_accept(name);
    Button_raw = 1'b1;
    wait_clk(60);
  endtask

  initial begin
    int p0, tk;
    int t4_idx[4] = '{1, 2, 3, 0};
    int t4_per[4] = '{250, 100, 50, 500};
    #1 Reset_n = 1'b0;
    wait_clk(3);
    Reset_n = 1'b1;

    // Idle after reset
    p0 = n_pulse; tk = 0;
    repeat (200) begin
      @(negedge Clock);
      if (Ms_tick) tk++;
    end
    check("t1_tick_count", tk, 20);
    check("t1_index", int'(Rate_index), 0);
    check("t1_period", int'(Half_period_ms), 500);
    check("t1_pulses", n_pulse - p0, 0);

    // Single clean press
    p0 = n_pulse;
    press_release("t2_latency");
    check("t2_pulses", n_pulse - p0, 1);
    check("t2_index", int'(Rate_index), 1);
    check("t2_period", int'(Half_period_ms), 250);

    // Bounce is rejected
    Reset_n = 1'b0; wait_clk(2); Reset_n = 1'b1; wait_clk(5);
    p0 = n_pulse;
    repeat (15) begin
      Button_raw = 1'b0; wait_clk(8);
      Button_raw = 1'b1; wait_clk(8);
    end
    wait_clk(40);
    check("t3_pulses", n_pulse - p0, 0);
    check("t3_index", int'(Rate_index), 0);

    // Four presses walk the table and wrap
    for (int k = 0; k < 4; k++) begin
      press_release("t4_latency");
      check("t4_index", int'(Rate_index), t4_idx[k]);
      check("t4_period", int'(Half_period_ms), t4_per[k]);
    end

    // Release glitches never produce a second pulse
    p0 = n_pulse;
    Button_raw = 1'b0;
    measure_accept("t5_latency");
    repeat (6) begin
      Button_raw = 1'b1; wait_clk(7);
      Button_raw = 1'b0; wait_clk(5);
    end
    Button_raw = 1'b1;
    wait_clk(60);
    check("t5_pulses", n_pulse - p0, 1);
    check("t5_index", int'(Rate_index), 1);
    press_release("t5_next_press");
    check("t5_next_index", int'(Rate_index), 2);
    check("t5_next_period", int'(Half_period_ms), 100);

    // Reset mid-debounce with the button held through release
    p0 = n_pulse;
    Button_raw = 1'b0;
    wait_clk(18);
    check("t6_no_early_pulse", n_pulse - p0, 0);
    #2 Reset_n = 1'b0;
    #1;
    check("t6_async_index", int'(Rate_index), 0);
    check("t6_async_period", int'(Half_period_ms), 500);
    check("t6_async_changed", int'(Rate_changed), 0);
    check("t6_async_tick", int'(Ms_tick), 0);
    wait_clk(3);
    Reset_n = 1'b1;
    measure_accept("t6_latency");
    Button_raw = 1'b1;
    wait_clk(60);
    check("t6_pulses", n_pulse - p0, 1);
    check("t6_index", int'(Rate_index), 1);
    check("t6_period", int'(Half_period_ms), 250);

    // Random button activity against the model
    repeat (80) begin
      Button_raw = 1'($urandom_range(0, 1));
      wait_clk(int'($urandom_range(1, 45)));
    end
    Button_raw = 1'b1;
    wait_clk(60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
